// File: rtl/sim_test_mon_if.sv
// ICB command-channel signal bundle observed by the simulation test monitor.
interface sim_test_mon_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              icb_cmd_valid;
  logic              icb_cmd_ready;
  logic              icb_cmd_read;
  logic [ADDR_W-1:0] icb_cmd_addr;
  logic [DATA_W-1:0] icb_cmd_wdata;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata,
    input  icb_cmd_ready
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata,
    output icb_cmd_ready
  );

  // Passive observer: every signal is an input.
  modport mon (
    input icb_cmd_valid, icb_cmd_ready, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata
  );
endinterface

// File: rtl/sim_test_mon.sv
// Passive simulation monitor: watches the ICB tohost mailbox, reports PASS/FAIL/TIMEOUT.
// Define SIM_TEST_MON_CH_CHECK_EN to require all DMA channels done before a pass.
module sim_test_mon #(
  parameter int unsigned              ADDR_W      = 32,
  parameter int unsigned              DATA_W      = 32,
  parameter logic [ADDR_W-1:0]        TOHOST_ADDR = ADDR_W'(32'h8000_1000),
  parameter int unsigned              TIMEOUT_CYC = 10_000_000,
  parameter int unsigned              N_CH        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  sim_test_mon_if.mon       icb,
  input  logic [N_CH-1:0]   ch_done,
  output logic [2:0]        state,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-2:0] fail_code,
  output logic [31:0]       cycle_cnt,
  output logic [N_CH-1:0]   ch_mask
);

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned CODE_W   = DATA_W - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                pass_q, fail_q, timeout_q;
  logic                mbox_wr;
  logic                pass_ok;

  assign mbox_wr = icb.icb_cmd_valid & icb.icb_cmd_ready & ~icb.icb_cmd_read &
                   (icb.icb_cmd_addr == TOHOST_ADDR);

`ifdef SIM_TEST_MON_CH_CHECK_EN
  assign pass_ok = &(mask_q | ch_done);
`else
  logic unused_ch_done;
  assign unused_ch_done = ^ch_done;
  assign pass_ok        = 1'b1;
`endif

  // Next-state and datapath; the cycle that leaves RUN does not advance the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
`ifdef SIM_TEST_MON_CH_CHECK_EN
        mask_d = mask_q | ch_done;
`endif
        if (mbox_wr) begin
          if (icb.icb_cmd_wdata == DATA_W'(1)) begin
            if (pass_ok) begin
              state_d = S_PASS;
            end else begin
              state_d = S_FAIL;
              code_d  = '1;
            end
          end else begin
            state_d = S_FAIL;
            code_d  = icb.icb_cmd_wdata[DATA_W-1:1];
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TIMEOUT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      code_q    <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      code_q    <= code_d;
      pass_q    <= (state_d == S_PASS);
      fail_q    <= (state_d == S_FAIL);
      timeout_q <= (state_d == S_TIMEOUT);
    end
  end

  assign state     = state_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_code = code_q;
  assign cycle_cnt = cnt_q;
  assign ch_mask   = mask_q;

endmodule
